vram_pixel_fetch: RTL and testbench

- Upstream pixel source for the 800x600 display timing stage.
- Consumes that stage's hcount/vcount and returns pdata, the 12-bit RGB for the pixel being scanned.
- Reads a 200x150 12-bit framebuffer held in a synchronous-read VRAM and scales it 4x in each axis.
- Overlays a blinking crosshair cursor.
- Uses a 2-cycle lookahead pipeline so that pdata lines up with the current hcount.

---
 rtl/vram_pixel_fetch.sv | 122 ++++++++++++
 tb/tb_vram_pixel_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_pixel_fetch.sv
// VRAM pixel fetch: 2-cycle lookahead, 4x scaled framebuffer read,
// blinking crosshair cursor overlay.
module vram_pixel_fetch #(
  parameter int H_TOTAL      = 1040,
  parameter int V_TOTAL      = 666,
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int FB_W         = 200,
  parameter int CUR_ARM      = 4,
  parameter logic [11:0] CUR_COLOR = 12'hFFF,
  parameter int BLINK_FRAMES = 36
) (
  input  logic        pclk,
  input  logic        rstn,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  input  logic        cursor_en,
  output logic [14:0] vram_addr,
  input  logic [11:0] vram_data,
  output logic [11:0] pdata
);

  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic signed [11:0] ARM = 12'(CUR_ARM);

  logic [11:0] h2;
  logic        wrap;
  logic [10:0] nh;
  logic [9:0]  nv;
  logic        act0;
  logic [14:0] y;
  logic [14:0] row;
  logic [14:0] addr0;
  logic signed [11:0] dh;
  logic signed [11:0] dv;
  logic        on_h;
  logic        on_v;
  logic        hit0;
  logic        frame;

  logic        act1;
  logic        hit1;
  logic        act2;
  logic        hit2;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [BW-1:0] cnt;
  logic        vis;

  // lookahead by two pixels, wrapping across line and frame
  always_comb begin
    h2   = {1'b0, hcount} + 12'd2;
    wrap = h2 >= 12'(H_TOTAL);
    nh   = wrap ? 11'(h2 - 12'(H_TOTAL)) : h2[10:0];
    nv   = vcount;
    if (wrap) begin
      nv = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end
  end

  always_comb begin
    act0 = (nh < 11'(H_ACTIVE)) && (nv < 10'(V_ACTIVE));
    y    = 15'(nv[9:2]);
    if (FB_W == 200) begin
      row = (y << 7) + (y << 6) + (y << 3);
    end else begin
      row = 15'(y * 15'(FB_W));
    end
    addr0 = row + 15'(nh[10:2]);
  end

  // signed distances so arms clip at screen edges
  always_comb begin
    dh   = $signed({1'b0, nh} - {2'b0, cx});
    dv   = $signed({2'b0, nv} - {2'b0, cy});
    on_h = (nv == cy) && (dh <= ARM) && (dh >= -ARM);
    on_v = (nh == {1'b0, cx}) && (dv <= ARM) && (dv >= -ARM);
    hit0 = act0 && cursor_en && vis && (on_h || on_v);
  end

  assign frame = (hcount == 11'(H_TOTAL - 1)) &&
                 (vcount == 10'(V_TOTAL - 1));

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      vram_addr <= '0;
      act1      <= 1'b0;
      hit1      <= 1'b0;
      act2      <= 1'b0;
      hit2      <= 1'b0;
    end else begin
      vram_addr <= act0 ? addr0 : 15'd0;
      act1      <= act0;
      hit1      <= hit0;
      act2      <= act1;
      hit2      <= hit1;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      cx  <= '0;
      cy  <= '0;
      cnt <= '0;
      vis <= 1'b1;
    end else if (frame) begin
      cx <= cursor_x;
      cy <= cursor_y;
      if (cnt == BW'(BLINK_FRAMES - 1)) begin
        cnt <= '0;
        vis <= ~vis;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pdata = hit2 ? CUR_COLOR : (act2 ? vram_data : 12'h000);

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// Scoreboard bench for vram_pixel_fetch: driver pushes expected address
// and pixel per cycle, a negedge monitor pops and compares.
module tb_vram_pixel_fetch;

  localparam int HT = 1040;
  localparam int VT = 666;
  localparam int FRAME = HT * VT;

  typedef struct {
    int          due;
    logic [14:0] val;
  } ent_t;

  logic        pclk = 1'b0;
  logic        rstn = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [9:0]  cursor_x = '0;
  logic [9:0]  cursor_y = '0;
  logic        cursor_en = 1'b0;
  logic [14:0] vram_addr;
  logic [11:0] vram_data = '0;
  logic [11:0] pdata;

  logic [11:0] mem [0:32767];
  ent_t qa[$];
  ent_t qp[$];
  int   ecyc = 0;
  int   total = 0;
  int   bad = 0;

  // reference model state
  int   m_cx, m_cy, m_cnt;
  bit   m_vis;
  int   sx, sy;
  bit   sen;

  vram_pixel_fetch dut (
    .pclk(pclk),
    .rstn(rstn),
    .hcount(hcount),
    .vcount(vcount),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .cursor_en(cursor_en),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .pdata(pdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) ecyc <= ecyc + 1;
  always @(posedge pclk) vram_data <= mem[vram_addr];

  always @(negedge pclk) begin
    ent_t e;
    while (qa.size() != 0 && qa[0].due <= ecyc) begin
      e = qa.pop_front();
      total++;
      if (e.due != ecyc || vram_addr !== e.val) begin
        bad++;
        $display("FAIL addr cyc=%0d got=%0d want=%0d due=%0d",
                 ecyc, vram_addr, e.val, e.due);
      end
    end
    while (qp.size() != 0 && qp[0].due <= ecyc) begin
      e = qp.pop_front();
      total++;
      if (e.due != ecyc || pdata !== e.val[11:0]) begin
        bad++;
        $display("FAIL pdata cyc=%0d got=%h want=%h due=%0d",
                 ecyc, pdata, e.val[11:0], e.due);
      end
    end
  end

  function automatic int iabs(int a);
    return a < 0 ? -a : a;
  endfunction

  task automatic model_reset();
    m_cx = 0;
    m_cy = 0;
    m_cnt = 0;
    m_vis = 1'b1;
  endtask

  task automatic rst_step();
    ent_t e;
    @(posedge pclk);
    #1;
    rstn = 1'b0;
    qa.delete();
    qp.delete();
    model_reset();
    e.due = ecyc;
    e.val = '0;
    qa.push_back(e);
    qp.push_back(e);
  endtask

  task automatic step(input int h, input int v);
    int p, nh, nv, a;
    bit act, hit;
    ent_t e;
    @(posedge pclk);
    #1;
    rstn = 1'b1;
    hcount = 11'(h);
    vcount = 10'(v);
    cursor_x = 10'(sx);
    cursor_y = 10'(sy);
    cursor_en = sen;
    p = v * HT + h + 2;
    if (p >= FRAME) p -= FRAME;
    nh = p % HT;
    nv = p / HT;
    act = (nh < 800) && (nv < 600);
    a = act ? (nv / 4) * 200 + nh / 4 : 0;
    hit = act && sen && m_vis &&
          ((nv == m_cy && iabs(nh - m_cx) <= 4) ||
           (nh == m_cx && iabs(nv - m_cy) <= 4));
    e.due = ecyc + 1;
    e.val = 15'(a);
    qa.push_back(e);
    e.due = ecyc + 2;
    e.val = hit ? 15'h0FFF : (act ? {3'b0, mem[a]} : 15'h0);
    qp.push_back(e);
    if (h == HT - 1 && v == VT - 1) begin
      m_cx = sx;
      m_cy = sy;
      if (m_cnt == 35) begin
        m_cnt = 0;
        m_vis = !m_vis;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic run_seq(input int h, input int v, input int n);
    int hh, vv;
    hh = h;
    vv = v;
    for (int i = 0; i < n; i++) begin
      step(hh, vv);
      hh++;
      if (hh == HT) begin
        hh = 0;
        vv = (vv == VT - 1) ? 0 : vv + 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 12'(i);
    mem[0] = 12'hABC;
    model_reset();
    sx = 0;
    sy = 0;
    sen = 1'b0;

    repeat (3) rst_step();
    run_seq(1038, 665, 40);

    run_seq(796, 0, 16);
    run_seq(400, 599, 16);
    for (int v = 0; v < 8; v++) run_seq(0, v, 20);
    run_seq(1030, 5, 20);

    run_seq(790, 3, 300);
    run_seq(0, 600, 30);
    run_seq(1035, 599, 10);
    run_seq(0, 665, 20);

    sen = 1'b1;
    sx = 400;
    sy = 300;
    for (int v = 294; v <= 306; v++) run_seq(390, v, 24);
    run_seq(1030, 665, 20);
    for (int v = 294; v <= 306; v++) run_seq(390, v, 24);

    sx = 2;
    sy = 0;
    run_seq(1030, 665, 30);
    for (int v = 0; v < 6; v++) run_seq(1030, v, 24);
    run_seq(1030, 665, 30);

    for (int f = 0; f < 80; f++) begin
      run_seq(1036, 665, 12);
      run_seq(0, 2, 6);
    end

    run_seq(500, 300, 10);
    repeat (2) rst_step();
    run_seq(510, 300, 20);
    run_seq(1030, 0, 16);
    run_seq(0, 3, 8);

    for (int k = 0; k < 150; k++) begin
      sen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        sx = $urandom_range(0, 799);
        sy = $urandom_range(0, 599);
        run_seq(1034, 665, 8);
      end
      if (k % 2 == 0) begin
        run_seq($urandom_range(0, HT - 1), $urandom_range(0, VT - 1), 20);
      end else begin
        run_seq((m_cx + HT - 8 + $urandom_range(0, 4)) % HT,
                (m_cy + VT - 5 + $urandom_range(0, 10)) % VT, 20);
      end
    end

    for (int k = 0; k < 1500; k++) begin
      sen = $urandom_range(0, 1) != 0;
      step($urandom_range(0, HT - 1), $urandom_range(0, VT - 1));
    end

    repeat (4) @(posedge pclk);
    @(negedge pclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
